// File: rtl/argmax_16_16_if.sv
// argmax_16_16_if
// Stream bundle between the last fully-connected layer, the argmax stage and
// the downstream consumer of the class label.
//   input_valid / input_ready / input_data    : score element stream
//   output_valid / output_ready / output_data : result index beat
//   output_max                                : maximum score, only present
//                                               when ARGMAX_VALUE_OUT_EN is defined
// Modports:
//   slave  - the argmax stage (consumes scores, produces the result)
//   master - the surrounding environment (produces scores, consumes result)
interface argmax_16_16_if #(
  parameter int N  = 16,
  parameter int T  = 16,
  parameter int IW = $clog2(N)
);
  logic                input_valid;
  logic                input_ready;
  logic signed [T-1:0] input_data;
  logic                output_valid;
  logic                output_ready;
  logic [IW-1:0]       output_data;
`ifdef ARGMAX_VALUE_OUT_EN
  logic signed [T-1:0] output_max;
`endif

  modport slave (
    input  input_valid, input_data, output_ready,
    output input_ready, output_valid, output_data
`ifdef ARGMAX_VALUE_OUT_EN
    , output output_max
`endif
  );

  modport master (
    output input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_data
`ifdef ARGMAX_VALUE_OUT_EN
    , input output_max
`endif
  );
endinterface

// File: rtl/argmax_16_16.sv
// argmax_16_16
// Consumes one vector of N signed T-bit scores, one element per accepted
// beat, and emits the index of the largest score as a single result beat.
// Ties keep the lowest index.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high
//   bus    - argmax_16_16_if.slave (score stream in, result beat out)
// Optional feature: define ARGMAX_VALUE_OUT_EN to expose the maximum score on
// bus.output_max.
//
// state   | meaning
// COLLECT | accepting elements, tracking running maximum
// HOLD    | presenting result, waiting for output_ready
module argmax_16_16 #(
  parameter int N = 16,
  parameter int T = 16
) (
  input  logic          clk,
  input  logic          reset,
  argmax_16_16_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q;
  logic [IW-1:0]       cnt_q;
  logic [IW-1:0]       best_idx_q;
  logic signed [T-1:0] best_val_q;
  logic                in_ready_q;
  logic                out_valid_q;

  // Handshake outputs come straight from registers: no input-to-output path.
  assign bus.input_ready  = in_ready_q;
  assign bus.output_valid = out_valid_q;
  assign bus.output_data  = best_idx_q;
`ifdef ARGMAX_VALUE_OUT_EN
  assign bus.output_max   = best_val_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.input_valid) begin
            // First element seeds the running maximum unconditionally.
            if (cnt_q == '0) begin
              best_val_q <= bus.input_data;
              best_idx_q <= '0;
            end else if ($signed(bus.input_data) > $signed(best_val_q)) begin
              best_val_q <= bus.input_data;
              best_idx_q <= cnt_q;
            end
            if (cnt_q == IW'(N - 1)) begin
              cnt_q       <= '0;
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + IW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.output_ready) begin
            state_q     <= COLLECT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= COLLECT;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_argmax_16_16.sv
module tb_argmax_16_16;
  localparam int N = 16;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  argmax_16_16_if #(.N(N), .T(T)) bus ();
  argmax_16_16 #(.N(N), .T(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [N*T-1:0] data;
    logic [3:0]     idx;
    logic [T-1:0]   mx;
  } vec_t;

  vec_t vecs[5];
  vec_t rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one element and wait (bounded) until it is accepted.
  task automatic accept(input logic [T-1:0] d);
    int w;
    bus.input_data  = d;
    bus.input_valid = 1'b1;
    w = 0;
    while (!bus.input_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 50) check("ready_timeout", {31'd0, bus.input_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_vec(input vec_t v, input bit gaps);
    for (int e = 0; e < N; e++) begin
      if (gaps) begin
        while ($urandom_range(1) == 1) begin
          bus.input_valid = 1'b0;
          bus.input_data  = 16'h7FFF;
          @(posedge clk); #1;
        end
      end
      accept(v.data[e*T +: T]);
    end
    bus.input_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, "_valid"}, {31'd0, bus.output_valid}, 32'd1);
    check({tag, "_idx"}, {28'd0, bus.output_data}, {28'd0, v.idx});
`ifdef ARGMAX_VALUE_OUT_EN
    check({tag, "_max"}, {16'd0, bus.output_max}, {16'd0, v.mx});
`endif
  endtask

  // Consume the result and confirm the stage is ready again next cycle.
  task automatic take_result(input string tag, input vec_t v);
    check_out(tag, v);
    bus.output_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_consumed"}, {31'd0, bus.output_valid}, 32'd0);
    check({tag, "_ready_after"}, {31'd0, bus.input_ready}, 32'd1);
  endtask

  function automatic logic [3:0] ref_idx(input logic [N*T-1:0] d);
    logic signed [T-1:0] b;
    logic [3:0] bi;
    b = d[T-1:0];
    bi = 4'd0;
    for (int i = 1; i < N; i++)
      if ($signed(d[i*T +: T]) > b) begin
        b = d[i*T +: T];
        bi = 4'(i);
      end
    return bi;
  endfunction

  initial begin
    int t0;
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.output_ready = 1'b0;

    // Vector table, expected values hand-computed.
    for (int i = 0; i < N; i++) begin
      vecs[0].data[i*T +: T] = 16'(i);                       // ascending
      vecs[1].data[i*T +: T] = (i == 7) ? 16'd300 : -16'sd5; // spike at 7
      vecs[2].data[i*T +: T] = 16'(-100 + i);                // negatives
      vecs[3].data[i*T +: T] = (i == 3 || i == 9) ? 16'h7FFF : 16'h0000; // tie
      vecs[4].data[i*T +: T] = (i == 0) ? 16'hFFFF : 16'h8000; // max at 0
    end
    vecs[0].idx = 4'd15; vecs[0].mx = 16'd15;
    vecs[1].idx = 4'd7;  vecs[1].mx = 16'd300;
    vecs[2].idx = 4'd15; vecs[2].mx = 16'hFFAB;
    vecs[3].idx = 4'd3;  vecs[3].mx = 16'h7FFF;
    vecs[4].idx = 4'd0;  vecs[4].mx = 16'hFFFF;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid", {31'd0, bus.output_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.input_ready}, 32'd1);
    check("rst_idx", {28'd0, bus.output_data}, 32'd0);
`ifdef ARGMAX_VALUE_OUT_EN
    check("rst_max", {16'd0, bus.output_max}, 32'd0);
`endif

    // Table-driven vectors, continuous valid, output_ready already high.
    bus.output_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_vec(vecs[k], 1'b0);
      take_result($sformatf("vec%0d", k), vecs[k]);
    end

    // Gapped input, result held for 5 cycles while HOLD ignores input.
    bus.output_ready = 1'b0;
    send_vec(vecs[1], 1'b1);
    bus.input_valid = 1'b1;
    bus.input_data  = 16'h7FFF;
    for (int c = 0; c < 5; c++) begin
      check_out("hold", vecs[1]);
      check("hold_ready", {31'd0, bus.input_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.input_valid = 1'b0;
    take_result("hold_take", vecs[1]);
    send_vec(vecs[2], 1'b0);
    take_result("after_hold", vecs[2]);

    // Reset mid-vector discards the partial result.
    for (int e = 0; e < 6; e++) accept((e == 1) ? 16'd1000 : 16'd0);
    bus.input_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_valid", {31'd0, bus.output_valid}, 32'd0);
    check("midrst_idx", {28'd0, bus.output_data}, 32'd0);
    check("midrst_ready", {31'd0, bus.input_ready}, 32'd1);
    for (int i = 0; i < N; i++) rv.data[i*T +: T] = (i == 2) ? 16'd42 : 16'(-i);
    rv.idx = 4'd2; rv.mx = 16'd42;
    for (int e = 0; e < N; e++) begin
      accept(rv.data[e*T +: T]);
      if (e < N - 1) check("midrst_no_spurious", {31'd0, bus.output_valid}, 32'd0);
    end
    bus.input_valid = 1'b0;
    take_result("midrst_vec", rv);

    // 100 back-to-back random vectors against the reference model.
    bus.output_ready = 1'b1;
    t0 = cyc;
    for (int v = 0; v < 100; v++) begin
      for (int i = 0; i < N; i++)
        rv.data[i*T +: T] = ($urandom_range(1) == 1) ? 16'($urandom) : 16'($urandom_range(7) - 4);
      rv.idx = ref_idx(rv.data);
      for (int i = 0; i < N; i++) if (4'(i) == rv.idx) rv.mx = rv.data[i*T +: T];
      for (int e = 0; e < N; e++) accept(rv.data[e*T +: T]);
      bus.input_data = 16'h7FFF;   // must be ignored during HOLD
      check_out($sformatf("rand%0d", v), rv);
      @(posedge clk); #1;
    end
    bus.input_valid = 1'b0;
    check("rand_throughput_cycles", 32'(cyc - t0), 32'(100 * (N + 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
